// File: rtl/hdr_frame_reader.sv
// Reads the idle half of the HDR double buffer into a 4-word prefetch FIFO; serves one RGB565 pixel per request.
// One-cycle pixel latency; ram_busy stalls issue, and reads are capped so FIFO plus in-flight never exceeds FIFO_DEPTH.
module hdr_frame_reader #(
  parameter logic [24:0] FRAME0_BASE     = 25'hE1000,
  parameter logic [24:0] FRAME1_BASE     = 25'h106800,
  parameter int          WORDS_PER_FRAME = 19200,
  parameter logic [24:0] ADDR_STEP       = 25'd4,
  parameter int          FIFO_DEPTH      = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         frame_start,
  input  logic         hdr_last_frame,
  input  logic         ram_busy,
  input  logic [255:0] rd_data,
  input  logic         rd_valid,
  input  logic         pixel_req,
  output logic         rd_req,
  output logic [24:0]  rd_address,
  output logic [15:0]  pixel_data,
  output logic         pixel_valid,
  output logic         underflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int WW = $clog2(WORDS_PER_FRAME + 1);

  typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;
  state_t state, state_nxt;

  logic [255:0]  mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_count, outstanding, discard, outs_nxt;
  logic [CW:0]   occupancy;
  logic [WW-1:0] word_cnt, consumed_cnt;
  logic [3:0]    pix_idx;
  logic [7:0]    bit_base;
  logic [15:0]   head_raw, head_pix;
  logic          push, serve, pop, starve, issue, streaming;

  assign streaming = (state == STREAM);
  assign push      = rd_valid && (discard == '0) && !frame_start;
  assign serve     = pixel_req && streaming && (fifo_count != '0) && !frame_start;
  assign starve    = pixel_req && streaming && (fifo_count == '0) && !frame_start;
  assign pop       = serve && (pix_idx == 4'd15);
  assign occupancy = {1'b0, fifo_count} + {1'b0, outstanding};
  assign outs_nxt  = outstanding + CW'(rd_req) - CW'(rd_valid);

  // rd_req low this cycle guarantees outstanding and word_cnt already include every issued read.
  assign issue = (state == FILL || state == STREAM) && !ram_busy && !rd_req && !frame_start
                 && (word_cnt < WW'(WORDS_PER_FRAME))
                 && (occupancy < (CW+1)'(FIFO_DEPTH));

  // Stored words hold pixels little-endian per byte pair; swap bytes back to RGB565.
  assign bit_base = {pix_idx, 4'b0000};
  assign head_raw = mem[rd_ptr][bit_base +: 16];
  assign head_pix = {head_raw[7:0], head_raw[15:8]};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (frame_start) begin
      state_nxt = FILL;
    end else begin
      case (state)
        FILL:    if (fifo_count == CW'(FIFO_DEPTH)) state_nxt = STREAM;
        STREAM:  if (pop && consumed_cnt == WW'(WORDS_PER_FRAME - 1)) state_nxt = DONE;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rd_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_req       <= 1'b0;
      rd_address   <= FRAME0_BASE;
      pixel_data   <= 16'h0000;
      pixel_valid  <= 1'b0;
      underflow    <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      outstanding  <= '0;
      discard      <= '0;
      word_cnt     <= '0;
      consumed_cnt <= '0;
      pix_idx      <= '0;
    end else begin
      rd_req      <= issue;
      pixel_valid <= pixel_req;
      if (pixel_req) pixel_data <= serve ? head_pix : 16'h0000;
      outstanding <= outs_nxt;
      if (frame_start) begin
        // Reads still in flight belong to the old frame and must be dropped on return.
        rd_address   <= hdr_last_frame ? FRAME0_BASE : FRAME1_BASE;
        discard      <= outs_nxt;
        underflow    <= 1'b0;
        wr_ptr       <= '0;
        rd_ptr       <= '0;
        fifo_count   <= '0;
        word_cnt     <= '0;
        consumed_cnt <= '0;
        pix_idx      <= '0;
      end else begin
        if (rd_req) begin
          rd_address <= rd_address + ADDR_STEP;
          word_cnt   <= word_cnt + WW'(1);
        end
        if (rd_valid && discard != '0) discard <= discard - CW'(1);
        if (push) wr_ptr <= wr_ptr + PW'(1);
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
        if (serve) pix_idx <= pix_idx + 4'd1;
        if (pop) begin
          rd_ptr       <= rd_ptr + PW'(1);
          consumed_cnt <= consumed_cnt + WW'(1);
        end
        if (starve) underflow <= 1'b1;
      end
    end
  end

endmodule

// File: doc/hdr_frame_reader.md
# hdr_frame_reader

Display-side consumer of the tone-mapped HDR frame buffer. It fetches 256-bit words of packed RGB565 pixels from SDRAM, from the half of the double buffer the tone mapper is not currently writing. It buffers the words in a 4-entry prefetch FIFO and serves one 16-bit pixel per display request. It sits between the SDRAM read port and the VGA output stage, mirroring the tone mapper's write path.

## Interface
- FRAME0_BASE, 25'hE1000, word address of buffer half 0
- FRAME1_BASE, 25'h106800, word address of buffer half 1
- WORDS_PER_FRAME, 19200, 256-bit words per frame (307200 px / 16)
- ADDR_STEP, 4, address increment per 256-bit word
- FIFO_DEPTH, 4, prefetch entries (power of two)

Reset and clock: reset rst_n, synchronous, active-low; clock clk.

- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- frame_start  in  1  one-cycle pulse from display at start of vertical blank
- hdr_last_frame  in  1  tone mapper is writing half 1 when high
- ram_busy  in  1  SDRAM controller cannot accept a request this cycle
- rd_data  in  256  read return data
- rd_valid  in  1  rd_data valid; returns in request order
- pixel_req  in  1  display consumes one pixel
- rd_req  out  1  one-cycle read request pulse
- rd_address  out  25  address qualified by rd_req
- pixel_data  out  16  RGB565 {R[4:0],G[5:0],B[4:0]}
- pixel_valid  out  1  pixel_data valid
- underflow  out  1  sticky; pixel requested while FIFO empty during STREAM

## Operation
- Reset values: rd_req=0, rd_address=FRAME0_BASE, pixel_data=0, pixel_valid=0, underflow=0; state IDLE; FIFO empty; all counters 0.
- States:
  - IDLE: no reads are issued. frame_start moves the block to FILL.
  - FILL: prefetch runs. When the FIFO is full, the block moves to STREAM.
  - STREAM: pixels are served. After the last word of the frame is consumed, the block moves to DONE.
  - DONE: black pixels are served. frame_start moves the block to FILL.
- On frame_start (any state):
  - sel <= ~hdr_last_frame.
  - rd_address <= sel ? FRAME1_BASE : FRAME0_BASE.
  - FIFO flushed; word_cnt=0, pix_idx=0, underflow cleared.
  - discard <= outstanding. The outstanding count here includes any rd_req issued in the same cycle.
- Request issue: rd_req=1 when state∈{FILL,STREAM}, ram_busy=0, rd_req=0 the previous cycle, word_cnt<WORDS_PER_FRAME, and fifo_count+outstanding<FIFO_DEPTH.
- On each issued request: rd_address += ADDR_STEP (registered after the pulse), word_cnt++, outstanding++.
- On rd_valid: outstanding--.
  - If discard>0, discard-- and drop the data.
  - Otherwise push rd_data into the FIFO.
- Unpack, for pixel i of the head word (i=pix_idx, 0..15): pixel_data = {w[16i+7:16i], w[16i+15:16i+8]}.
- pixel_req in STREAM with FIFO non-empty: output the head pixel and increment pix_idx. At pix_idx=15, pop the FIFO and wrap pix_idx to 0; consumed_cnt++.
- pixel_req in STREAM with FIFO empty: output 16'h0000 and set underflow. pix_idx does not advance.
- pixel_req in IDLE, FILL or DONE: output 16'h0000. underflow is unchanged.
- Simultaneous rd_valid push and pix_idx=15 pop on the same cycle: both take effect; fifo_count is unchanged.
- frame_start coinciding with pixel_req: the flush wins; the output pixel is 0.

## Timing
- pixel_valid is high exactly one cycle after pixel_req, with pixel_data registered in that same cycle.
- Data pushed at cycle N is readable by a pixel_req at N+1.
- rd_req is never high in two consecutive cycles. The maximum request rate is one per 2 cycles.
- FILL→STREAM occurs the cycle after fifo_count reaches FIFO_DEPTH. Latency is at least 2×FIFO_DEPTH cycles plus RAM latency.
- Address sequence per frame: base, base+4, …, base+4×(WORDS_PER_FRAME−1). There is no wrap within a frame.

## Test plan
- Reset, then frame_start with hdr_last_frame=1. Required: rd_address sequence starting at 25'hE1000, rd_req spaced ≥2 cycles, FILL→STREAM after 4 rd_valid.
- Return word with w[15:0]=16'h1FA5. Required: first pixel_data = 16'hA51F, valid one cycle after pixel_req; 16 requests pop exactly one word.
- Hold ram_busy=1 for 20 cycles during FILL. Required: no rd_req and no address advance; resume on release.
- Issue pixel_req every cycle with RAM latency 40. Required: underflow=1, pixel_data=0 on empty cycles, pix_idx held.
- Issue frame_start with 2 reads outstanding and hdr_last_frame=0. Required: the next 2 rd_valid are discarded, new addresses start at 25'h106800, underflow cleared.
- Run a full frame with WORDS_PER_FRAME=8. Required: exactly 8 rd_req, state DONE after 128 pixels, subsequent pixel_data=0 with no underflow.
